// File: rtl/tone_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tone_period_meter
// Description : Measures the half-period of a square wave on the 1 MHz clock
//               and reports it on the buzzer generator's divider scale.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_period_meter #(
   parameter int TIMEOUT  = 2047,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 2,
   parameter int MIN_DIV  = 1
) (
   input  logic        clk_1mhz,
   input  logic        rst_n,
   input  logic        wave_in,
   output logic [10:0] div_est,
   output logic        tone_present,
   output logic        meas_valid
);

   localparam logic [11:0] c_timeout  = 12'(TIMEOUT);
   localparam logic [11:0] c_tol      = 12'(TOL);
   localparam logic [2:0]  c_lock_cnt = 3'(LOCK_CNT);
   localparam logic [10:0] c_min_div  = 11'(MIN_DIV);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_s1;
   logic        r_s2;
   logic        r_s3;
   logic [11:0] r_cnt;
   logic [10:0] r_prev_meas;
   logic        r_prev_valid;
   logic [2:0]  r_match_cnt;
   logic [10:0] r_div_est;
   logic        r_meas_valid;

   logic [10:0] w_prev_meas_nxt;
   logic        w_prev_valid_nxt;
   logic [2:0]  w_match_cnt_nxt;
   logic [10:0] w_div_est_nxt;
   logic        w_meas_valid_nxt;

   logic        w_edge;
   logic [10:0] w_meas;
   logic [11:0] w_diff;
   logic [11:0] w_abs;
   logic        w_match;
   logic        w_glitch;
   logic        w_timeout;
   logic [2:0]  w_match_inc;

   assign w_edge      = r_s2 ^ r_s3;
   assign w_meas      = r_cnt[10:0];
   // 12-bit two's-complement difference; bit 11 is the sign, so no wrap
   assign w_diff      = {1'b0, w_meas} - {1'b0, r_prev_meas};
   assign w_abs       = w_diff[11] ? (12'd0 - w_diff) : w_diff;
   assign w_match     = r_prev_valid && (w_abs <= c_tol);
   assign w_glitch    = (w_meas < c_min_div);
   assign w_timeout   = (r_cnt == c_timeout);
   assign w_match_inc = r_match_cnt + 3'd1;

   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= wave_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 12'd0;
      end else if (w_edge) begin
         r_cnt <= 12'd0;
      end else if (r_cnt < c_timeout) begin
         r_cnt <= r_cnt + 12'd1;
      end
   end

   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_prev_meas  <= 11'd0;
         r_prev_valid <= 1'b0;
         r_match_cnt  <= 3'd0;
         r_div_est    <= 11'd0;
         r_meas_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_prev_meas  <= w_prev_meas_nxt;
         r_prev_valid <= w_prev_valid_nxt;
         r_match_cnt  <= w_match_cnt_nxt;
         r_div_est    <= w_div_est_nxt;
         r_meas_valid <= w_meas_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_prev_meas_nxt  = r_prev_meas;
      w_prev_valid_nxt = r_prev_valid;
      w_match_cnt_nxt  = r_match_cnt;
      w_div_est_nxt    = r_div_est;
      w_meas_valid_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // The first edge only starts the count; it has no valid interval
            if (w_edge) begin
               w_state_nxt      = ST_ACQUIRE;
               w_prev_valid_nxt = 1'b0;
               w_match_cnt_nxt  = 3'd0;
            end
         end

         ST_ACQUIRE: begin
            if (w_edge) begin
               if (w_glitch) begin
                  w_prev_valid_nxt = 1'b0;
                  w_match_cnt_nxt  = 3'd0;
               end else if (!w_match) begin
                  w_prev_meas_nxt  = w_meas;
                  w_prev_valid_nxt = 1'b1;
                  w_match_cnt_nxt  = 3'd0;
               end else begin
                  w_prev_meas_nxt = w_meas;
                  w_match_cnt_nxt = w_match_inc;
                  if (w_match_inc == c_lock_cnt) begin
                     w_state_nxt      = ST_LOCKED;
                     w_div_est_nxt    = w_meas;
                     w_meas_valid_nxt = 1'b1;
                  end
               end
            end else if (w_timeout) begin
               w_state_nxt      = ST_IDLE;
               w_div_est_nxt    = 11'd0;
               w_prev_valid_nxt = 1'b0;
            end
         end

         ST_LOCKED: begin
            if (w_edge) begin
               w_prev_meas_nxt = w_meas;
               if (!w_glitch && w_match) begin
                  w_div_est_nxt    = w_meas;
                  w_meas_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt      = ST_ACQUIRE;
                  w_match_cnt_nxt  = 3'd0;
                  w_div_est_nxt    = 11'd0;
                  w_prev_valid_nxt = !w_glitch;
               end
            end else if (w_timeout) begin
               w_state_nxt      = ST_IDLE;
               w_div_est_nxt    = 11'd0;
               w_prev_valid_nxt = 1'b0;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign div_est      = r_div_est;
   assign meas_valid   = r_meas_valid;
   assign tone_present = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tone_period_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tone_period_meter
// Description : Directed self-checking bench for tone_period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_period_meter;

   localparam int c_timeout = 2047;

   logic        clk_1mhz;
   logic        rst_n;
   logic        wave_in;
   logic [10:0] div_est;
   logic        tone_present;
   logic        meas_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int mv_count = 0;
   int mv_base;
   int s_tp;
   int s_de;
   int s_mv;

   tone_period_meter #(
      .TIMEOUT  (c_timeout),
      .TOL      (1),
      .LOCK_CNT (2),
      .MIN_DIV  (1)
   ) u_dut (
      .clk_1mhz     (clk_1mhz),
      .rst_n        (rst_n),
      .wave_in      (wave_in),
      .div_est      (div_est),
      .tone_present (tone_present),
      .meas_valid   (meas_valid)
   );

   initial begin
      clk_1mhz = 1'b0;
      forever #500 clk_1mhz = ~clk_1mhz;
   end

   always @(negedge clk_1mhz) begin
      if (meas_valid) mv_count++;
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Toggle the input, sample outputs once the resulting edge has been
   // consumed (3 falling edges later), then hold for the rest of h cycles.
   task automatic half(input int h);
      wave_in = ~wave_in;
      repeat (3) @(negedge clk_1mhz);
      s_tp = int'(tone_present);
      s_de = int'(div_est);
      s_mv = int'(meas_valid);
      repeat (h - 3) @(negedge clk_1mhz);
   endtask

   initial begin
      #40_000_000;
      check_val("watchdog", 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      rst_n   = 1'b0;
      wave_in = 1'b0;
      #10;
      check_val("rst_tp", int'(tone_present), 0);
      check_val("rst_de", int'(div_est), 0);
      check_val("rst_mv", int'(meas_valid), 0);
      repeat (3) @(negedge clk_1mhz);
      rst_n = 1'b1;
      repeat (100) @(negedge clk_1mhz);
      check_val("idle_low_tp", int'(tone_present), 0);
      check_val("idle_low_de", int'(div_est), 0);

      // Steady tone, div_max 499
      repeat (3) half(500);
      check_val("steady_pre_lock_tp", s_tp, 0);
      half(500);
      check_val("steady_lock_tp", s_tp, 1);
      check_val("steady_lock_de", s_de, 499);
      check_val("steady_lock_mv", s_mv, 1);
      mv_base = mv_count;
      repeat (4) half(500);
      check_val("steady_mv_count", mv_count - mv_base, 4);
      check_val("steady_de", s_de, 499);

      // Jitter within tolerance: half-periods 300/301
      half(300);
      check_val("jit_first_de", s_de, 499);
      half(301);
      check_val("jit_drop_tp", s_tp, 0);
      check_val("jit_drop_de", s_de, 0);
      half(300);
      half(301);
      check_val("jit_lock_tp", s_tp, 1);
      check_val("jit_lock_de", s_de, 299);
      for (int k = 5; k <= 8; k++) begin
         half((k % 2 == 1) ? 300 : 301);
         check_val("jit_tp", s_tp, 1);
         check_val("jit_de", s_de, (k % 2 == 0) ? 299 : 300);
      end

      // Frequency step 499 -> 99
      repeat (4) half(500);
      check_val("step_lock499_de", s_de, 499);
      half(500);
      half(100);
      check_val("step_last_long_de", s_de, 499);
      half(100);
      check_val("step_drop_tp", s_tp, 0);
      check_val("step_drop_de", s_de, 0);
      half(100);
      half(100);
      check_val("step_relock_tp", s_tp, 1);
      check_val("step_relock_de", s_de, 99);

      // Glitch while locked at 250
      repeat (4) half(251);
      check_val("glitch_lock_de", s_de, 250);
      half(251);
      half(125);
      check_val("glitch_pre_de", s_de, 250);
      wave_in = ~wave_in;
      @(negedge clk_1mhz);
      wave_in = ~wave_in;
      repeat (3) @(negedge clk_1mhz);
      check_val("glitch_drop_tp", int'(tone_present), 0);
      check_val("glitch_drop_de", int'(div_est), 0);
      repeat (122) @(negedge clk_1mhz);
      repeat (3) half(251);
      check_val("glitch_acq_tp", s_tp, 0);
      half(251);
      check_val("glitch_relock_tp", s_tp, 1);
      check_val("glitch_relock_de", s_de, 250);

      // Asynchronous reset while locked
      repeat (50) @(negedge clk_1mhz);
      #100;
      rst_n = 1'b0;
      #1;
      check_val("arst_tp", int'(tone_present), 0);
      check_val("arst_de", int'(div_est), 0);
      check_val("arst_mv", int'(meas_valid), 0);
      wave_in = 1'b0;
      repeat (2) @(negedge clk_1mhz);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_1mhz);
      repeat (3) half(251);
      check_val("arst_pre_lock_tp", s_tp, 0);
      half(251);
      check_val("arst_relock_tp", s_tp, 1);
      check_val("arst_relock_de", s_de, 250);

      // Silence: last edge then hold the input
      half(251);
      wave_in = ~wave_in;
      repeat (c_timeout + 3) @(negedge clk_1mhz);
      check_val("silence_before_tp", int'(tone_present), 1);
      check_val("silence_before_de", int'(div_est), 250);
      @(negedge clk_1mhz);
      check_val("silence_tp", int'(tone_present), 0);
      check_val("silence_de", int'(div_est), 0);
      repeat (200) @(negedge clk_1mhz);
      check_val("silence_hold_tp", int'(tone_present), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tone_period_meter.md
# tone_period_meter

Receive-side companion to the buzzer tone generator. Measures the half-period of an incoming square wave on the 1 MHz system clock and reports it as a divider value. The scale matches the generator's `div_max` input, so a tone produced with divider N reads back as N. Used for self-test loopback of the buzzer path and for detecting external tone inputs; silence reads back as 0, the same encoding the generator uses for "off".

## Interface
- `TIMEOUT`, default 2047: cycles without an edge before the input is declared silent; legal range 2..2048.
- `TOL`, default 1: maximum |difference| between consecutive half-period measurements that still counts as a match.
- `LOCK_CNT`, default 2: number of consecutive matches required to declare lock; legal range 1..7.
- `MIN_DIV`, default 1: measurements below this are treated as glitches.
- `clk_1mhz`  input  1  system clock, 1 MHz.
- `rst_n`  input  1  asynchronous, active-low reset.
- `wave_in`  input  1  square wave, asynchronous to `clk_1mhz`.
- `div_est`  output  11  measured divider value; 0 when no tone is locked.
- `tone_present`  output  1  high while in LOCKED.
- `meas_valid`  output  1  one-cycle pulse on each accepted measurement while locked.

## Operation
- **Input conditioning:** `wave_in` passes through a 2-flop synchronizer (s1, s2) and a third flop (s3). The edge pulse is `edge = s2 ^ s3`; both polarities count.
- **Counter `cnt`:** 12 bits, unsigned.
  - On an edge cycle, `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`, saturating at `TIMEOUT`.
  - On an edge cycle, `meas = cnt[10:0]`. Edges spaced D cycles apart give `meas = D - 1`, which equals the generator's `div_max`.
- **Match rule:** `match = prev_valid && |meas - prev_meas| <= TOL`. Compute it with 12-bit signed difference; never wrap.
- **States:** IDLE, ACQUIRE, LOCKED. Reset state is IDLE.
- **IDLE**
  - On edge: go to ACQUIRE. `prev_valid = 0`, `match_cnt = 0`, no measurement taken.
- **ACQUIRE**
  - On edge with `meas < MIN_DIV`: `prev_valid = 0`, `match_cnt = 0`, stay in ACQUIRE.
  - On edge with no match: `prev_meas = meas`, `prev_valid = 1`, `match_cnt = 0`.
  - On edge with a match: `match_cnt + 1`. When that value reaches `LOCK_CNT`, go to LOCKED, load `div_est = meas`, pulse `meas_valid`.
  - Always on an edge (non-glitch): `prev_meas = meas`.
- **LOCKED**
  - On edge with a match (and `meas >= MIN_DIV`): `div_est = meas`, pulse `meas_valid`, `prev_meas = meas`.
  - On edge with a mismatch or glitch: go to ACQUIRE, `match_cnt = 0`, `div_est = 0`. `prev_meas = meas` and `prev_valid = 1`, except a glitch sets `prev_valid = 0`.
- **Timeout:** in ACQUIRE or LOCKED, if `cnt == TIMEOUT` with no edge this cycle, go to IDLE, `div_est = 0`, `prev_valid = 0`.
- **Priority:** edge beats timeout in the same cycle.
- **Outputs:** `tone_present = (state == LOCKED)`, registered with the state.

## Timing
- Reset values: `div_est = 0`, `tone_present = 0`, `meas_valid = 0`, `cnt = 0`, `state = IDLE`, s1/s2/s3 = 0.
- `rst_n` asserted mid-lock clears everything immediately (asynchronously). The first edge after release is never measured.
- Latency, input transition to `edge` high: 2–3 clock edges, depending on sampling phase.
- `div_est`, `tone_present` and `meas_valid` update on the clock edge following the `edge` cycle.
- For a steady tone with divider N, lock completes at edge number `LOCK_CNT + 2` after the first input transition.
- `meas_valid` is never high for two consecutive cycles; minimum spacing is `MIN_DIV + 1` cycles.
- Silence is detected `TIMEOUT + 1` cycles after the last edge. `div_est` is 0 and `tone_present` is 0 the cycle after.
- An all-zero or all-one input never leaves IDLE.

## Test plan
- **Steady tone:** generator `div_max = 499` looped into `wave_in` → `tone_present` = 1 after 4 edges, `div_est` = 499, `meas_valid` every 500 cycles.
- **Jitter within tolerance:** half-periods alternating 300/301 cycles, `TOL = 1` → stays LOCKED, `div_est` alternates 299/300.
- **Frequency step:** `div_max` changes 499 → 99 while locked → drop to ACQUIRE with `div_est` = 0, relock with `div_est` = 99 within 3 short half-periods.
- **Silence:** `div_max = 0` (input held low) → `tone_present` falls exactly 2048 cycles after the last edge (`TIMEOUT` = 2047); `div_est` = 0.
- **Glitch:** a 1-cycle pulse injected mid-period while locked at 250 → `meas` below `MIN_DIV` or mismatch, leave LOCKED, relock at 250.
- **Reset mid-operation:** `rst_n` pulsed low while locked → all outputs 0 immediately; relock requires `LOCK_CNT + 2` edges.
